// File: rtl/sap1_controller_sequencer_if.sv
// Control-word bundle between the SAP-1 sequencer and the datapath.
// The master side is the controller; the slave side is the datapath or observer.
interface sap1_controller_sequencer_if #(
    parameter int OPW   = 4,
    parameter int NUM_T = 6
);
    logic             step_en;
    logic [OPW-1:0]   ir_opcode;
    logic [NUM_T-1:0] t_state;
    logic             Cp;
    logic             Ep;
    logic             Lm_bar;
    logic             CE_bar;
    logic             Li_bar;
    logic             Ei_bar;
    logic             La_bar;
    logic             Ea;
    logic             Su;
    logic             Eu;
    logic             Lb_bar;
    logic             Lo_bar;
    logic             hlt;

    modport master (
        input  step_en, ir_opcode,
        output t_state, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar,
               La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, hlt
    );

    modport slave (
        output step_en, ir_opcode,
        input  t_state, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar,
               La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, hlt
    );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: 6-state one-hot ring counter plus opcode decode
// into the 12-bit control word and the HLT flag.
module sap1_controller_sequencer #(
    parameter int OPW   = 4,
    parameter int NUM_T = 6
) (
    input  logic                         CLK,
    input  logic                         CLR,
    sap1_controller_sequencer_if.master  bus
);

    localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

    // Encoding is the one-hot ring itself, so t_state is the state register.
    typedef enum logic [NUM_T-1:0] {
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000,
        HALTED = 6'b000000
    } state_t;

    state_t state, state_nxt;
    logic   run;
    logic   is_alu;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= T1;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T1:      state_nxt = T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = T4;
            T4:      state_nxt = (bus.ir_opcode == OP_HLT) ? HALTED : T5;
            T5:      state_nxt = T6;
            T6:      state_nxt = T1;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = T1;
        endcase
        if (!bus.step_en && state != HALTED) state_nxt = state;
    end

    // The word is gated by step_en so a frozen sequencer never repeats a load or Cp.
    assign run    = !CLR && bus.step_en && (state != HALTED);
    assign is_alu = (bus.ir_opcode == OP_ADD) || (bus.ir_opcode == OP_SUB);

    always_comb begin
        bus.Cp     = 1'b0;
        bus.Ep     = 1'b0;
        bus.Lm_bar = 1'b1;
        bus.CE_bar = 1'b1;
        bus.Li_bar = 1'b1;
        bus.Ei_bar = 1'b1;
        bus.La_bar = 1'b1;
        bus.Ea     = 1'b0;
        bus.Su     = 1'b0;
        bus.Eu     = 1'b0;
        bus.Lb_bar = 1'b1;
        bus.Lo_bar = 1'b1;
        if (run) begin
            case (state)
                T1: begin
                    bus.Ep     = 1'b1;
                    bus.Lm_bar = 1'b0;
                end
                T2: bus.Cp = 1'b1;
                T3: begin
                    bus.CE_bar = 1'b0;
                    bus.Li_bar = 1'b0;
                end
                T4: begin
                    if (bus.ir_opcode == OP_LDA || is_alu) begin
                        bus.Ei_bar = 1'b0;
                        bus.Lm_bar = 1'b0;
                    end else if (bus.ir_opcode == OP_OUT) begin
                        bus.Ea     = 1'b1;
                        bus.Lo_bar = 1'b0;
                    end
                end
                T5: begin
                    if (bus.ir_opcode == OP_LDA) begin
                        bus.CE_bar = 1'b0;
                        bus.La_bar = 1'b0;
                    end else if (is_alu) begin
                        bus.CE_bar = 1'b0;
                        bus.Lb_bar = 1'b0;
                    end
                end
                T6: begin
                    if (is_alu) begin
                        bus.Eu     = 1'b1;
                        bus.La_bar = 1'b0;
                        bus.Su     = (bus.ir_opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // hlt rises during T4 of HLT so clock gating can prepare before the edge.
    assign bus.hlt     = !CLR && ((state == HALTED) ||
                                  (state == T4 && bus.ir_opcode == OP_HLT));
    assign bus.t_state = state;

endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
- Controller-sequencer for the SAP-1 datapath.
- A 6-state ring counter (T1..T6) sequences every instruction. Each state is decoded with the IR opcode into the 12-bit control word.
- The control word drives the PC, MAR, RAM, IR, accumulator, B register, adder/subtractor and output register; Lm_bar drives the MAR load input.
- Sits between the IR opcode nibble and all datapath load/enable pins; also supplies HLT to clock gating.

Parameters:
- OPW, 4, opcode width (IR upper nibble).
- NUM_T, 6, ring-counter length. Fixed at 6; other values unsupported.

Ports:
- CLK  input  1  system clock; state advances on rising edge.
- CLR  input  1  asynchronous active-high reset.
- step_en  input  1  1 = run; 0 = freeze sequencer and idle the bus (single-step).
- ir_opcode  input  OPW  opcode from IR; valid T4..T6.
- t_state  output  NUM_T  one-hot ring state, bit0 = T1; all-zero when halted.
- Cp  output  1  PC increment.
- Ep  output  1  PC to bus.
- Lm_bar  output  1  MAR load, active low.
- CE_bar  output  1  RAM to bus, active low.
- Li_bar  output  1  IR load, active low.
- Ei_bar  output  1  IR address to bus, active low.
- La_bar  output  1  accumulator load, active low.
- Ea  output  1  accumulator to bus.
- Su  output  1  1 = subtract.
- Eu  output  1  adder/subtractor to bus.
- Lb_bar  output  1  B load, active low.
- Lo_bar  output  1  output register load, active low.
- hlt  output  1  halted flag.

Behaviour:
- Inactive word (NOP): Cp=0, Ep=0, Lm_bar=1, CE_bar=1, Li_bar=1, Ei_bar=1, La_bar=1, Ea=0, Su=0, Eu=0, Lb_bar=1, Lo_bar=1.
- Reset:
  - CLR=1 forces t_state=000001 and hlt=0 immediately, independent of CLK.
  - All control outputs are forced to NOP while CLR=1.
  - After CLR deasserts, T1 decode applies until the next rising edge.
- Sequencing:
  - On each rising edge with step_en=1 and not halted: T1→T2→…→T6→T1.
  - With step_en=0: state holds and control outputs are NOP. This prevents a repeated Cp or load while frozen.
- Control outputs are combinational from (t_state, ir_opcode, step_en, CLR, halted). There is no added latency: signals are valid in the same state and are sampled by the datapath at the rising edge ending that state.
- Fetch states (all opcodes):
  - T1: Ep=1, Lm_bar=0.
  - T2: Cp=1.
  - T3: CE_bar=0, Li_bar=0.
- Execute states:
  - LDA 0000: T4 Ei_bar=0, Lm_bar=0 | T5 CE_bar=0, La_bar=0 | T6 NOP.
  - ADD 0001: T4 Ei_bar=0, Lm_bar=0 | T5 CE_bar=0, Lb_bar=0 | T6 Eu=1, La_bar=0, Su=0.
  - SUB 0010: T4 and T5 as ADD | T6 Eu=1, La_bar=0, Su=1.
  - OUT 1110: T4 Ea=1, Lo_bar=0 | T5 NOP | T6 NOP.
  - HLT 1111: T4 outputs NOP and hlt=1 combinationally. At the rising edge ending T4 (step_en=1), enter HALTED.
  - Any other opcode: T4..T6 NOP; the sequence continues normally.
- HALTED:
  - t_state=000000, hlt=1, all outputs NOP.
  - Ignores CLK, step_en and ir_opcode. Exited only by CLR.
- Bus exclusivity: at most one of Ep, CE_bar(low), Ei_bar(low), Ea, Eu is active in any state. Bench asserts this every cycle.
- CLR mid-instruction (any T state or HALTED): immediate return to T1 with NOP outputs. No partial-instruction state is retained.
- Simultaneous CLR and a rising edge: CLR wins.
- ir_opcode changes during T1..T3 do not affect outputs.

Test Plan:
- Reset: CLR=1 at any time → t_state=000001, NOP word, hlt=0. Release CLR → Ep=1, Lm_bar=0. After 1 edge → t_state=000010, Cp=1, Lm_bar=1.
- LDA fetch/execute, ir_opcode=0000, 6 edges → T1 Ep/Lm_bar=0; T2 Cp; T3 CE_bar/Li_bar=0; T4 Ei_bar/Lm_bar=0; T5 CE_bar/La_bar=0; T6 NOP; 7th state=000001. Lm_bar low exactly in T1 and T4.
- SUB, ir_opcode=0010 → T5 Lb_bar=0, CE_bar=0; T6 Eu=1, Su=1, La_bar=0. Same with 0001 → T6 Su=0.
- HLT, ir_opcode=1111 → hlt=1 during T4. After the edge: t_state=000000. Hold 10 cycles with step_en toggling → no change. CLR pulse → t_state=000001, hlt=0.
- Step: step_en=0 for 3 cycles during T2 → t_state stays 000010, Cp=0 throughout. step_en=1 → Cp=1, then T3 on the next edge.
- Mid-op reset and unknown opcode:
  - CLR asserted in T5 of ADD → t_state=000001 immediately, no La_bar/Lb_bar pulse.
  - ir_opcode=0101 → T4..T6 NOP, then T1.
